// File: rtl/pipe_elastic_wbreg_if.sv
// pipe_elastic_wbreg_if: writeback-bundle handshake bundle.
// The slave modport is the stage; the master modport drives the stage from upstream and downstream.
interface pipe_elastic_wbreg_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic          in_wreg;
    logic          in_m2reg;
    logic [DW-1:0] in_mo;
    logic [DW-1:0] in_alu;
    logic [RW-1:0] in_rn;
    logic          out_valid;
    logic          out_ready;
    logic          out_wreg;
    logic          out_m2reg;
    logic [DW-1:0] out_mo;
    logic [DW-1:0] out_alu;
    logic [RW-1:0] out_rn;
    logic [1:0]    occupancy;
    modport slave (
        input  in_valid, in_wreg, in_m2reg, in_mo, in_alu, in_rn, out_ready,
        output in_ready, out_valid, out_wreg, out_m2reg, out_mo, out_alu, out_rn, occupancy
    );
    modport master (
        output in_valid, in_wreg, in_m2reg, in_mo, in_alu, in_rn, out_ready,
        input  in_ready, out_valid, out_wreg, out_m2reg, out_mo, out_alu, out_rn, occupancy
    );
endinterface

// File: rtl/pipe_elastic_wbreg.sv
// pipe_elastic_wbreg: elastic two-entry MEM/WB register (head + skid) with flush.
// Optional PIPE_ELASTIC_PERF_EN adds saturating stall_cnt / bubble_cnt outputs.
module pipe_elastic_wbreg #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
`ifdef PIPE_ELASTIC_PERF_EN
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] bubble_cnt,
`endif
    pipe_elastic_wbreg_if.slave bus
);
    typedef struct packed {
        logic          wreg;
        logic          m2reg;
        logic [DW-1:0] mo;
        logic [DW-1:0] alu;
        logic [RW-1:0] rn;
    } beat_t;
    beat_t head_q, head_d, skid_q, skid_d, in_b;
    logic hv_q, hv_d, sv_q, sv_d, acc, pop;
    logic [1:0] occ_q, occ_d;
    assign in_b = {bus.in_wreg, bus.in_m2reg, bus.in_mo, bus.in_alu, bus.in_rn};
    assign acc  = bus.in_valid & ~sv_q;
    assign pop  = hv_q & bus.out_ready;
    always_comb begin
        hv_d   = hv_q;
        sv_d   = sv_q;
        head_d = head_q;
        skid_d = skid_q;
        if (flush) begin
            hv_d         = 1'b0;
            sv_d         = 1'b0;
            head_d.wreg  = 1'b0;
            head_d.m2reg = 1'b0;
            skid_d.wreg  = 1'b0;
            skid_d.m2reg = 1'b0;
        end else begin
            // Head refills from skid first (FIFO order), else from the input; an empty head keeps control fields at 0.
            if (!hv_q || pop) begin
                hv_d   = sv_q | acc;
                head_d = sv_q ? skid_q : acc ? in_b : head_q;
                if (!(sv_q | acc)) begin
                    head_d.wreg  = 1'b0;
                    head_d.m2reg = 1'b0;
                end
            end
            if (sv_q && pop) begin
                sv_d = 1'b0;
            end else if (hv_q && !pop && acc) begin
                sv_d   = 1'b1;
                skid_d = in_b;
            end
        end
        occ_d = {1'b0, hv_d} + {1'b0, sv_d};
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hv_q   <= 1'b0;
            sv_q   <= 1'b0;
            head_q <= '0;
            skid_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            hv_q   <= hv_d;
            sv_q   <= sv_d;
            head_q <= head_d;
            skid_q <= skid_d;
            occ_q  <= occ_d;
        end
    end
    assign bus.in_ready  = ~sv_q;
    assign bus.out_valid = hv_q;
    assign bus.out_wreg  = head_q.wreg;
    assign bus.out_m2reg = head_q.m2reg;
    assign bus.out_mo    = head_q.mo;
    assign bus.out_alu   = head_q.alu;
    assign bus.out_rn    = head_q.rn;
    assign bus.occupancy = occ_q;
`ifdef PIPE_ELASTIC_PERF_EN
    logic [CW-1:0] stall_q, bubble_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_q + CW'(hv_q & ~bus.out_ready & ~&stall_q);
            bubble_q <= bubble_q + CW'((~hv_q | flush) & ~&bubble_q);
        end
    end
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_pipe_elastic_wbreg.sv
// tb_pipe_elastic_wbreg: directed + random stimulus against a queue model of the stage.
// Counters use CW = 4 so saturation is reached quickly when PIPE_ELASTIC_PERF_EN is defined.
module tb_pipe_elastic_wbreg;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    typedef struct {
        logic          w;
        logic          m;
        logic [DW-1:0] mo;
        logic [DW-1:0] alu;
        logic [RW-1:0] rn;
    } beat_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int checks = 0;
    int errors = 0;
    beat_t q[$];
    int stall_m = 0;
    int bubble_m = 0;
    localparam int CMAX = (1 << CW) - 1;
    pipe_elastic_wbreg_if #(.DW(DW), .RW(RW)) bus ();
`ifdef PIPE_ELASTIC_PERF_EN
    logic [CW-1:0] stall_cnt, bubble_cnt;
    pipe_elastic_wbreg #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .bus(bus));
`else
    pipe_elastic_wbreg #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clock(clock), .reset(reset), .flush(flush), .bus(bus));
`endif
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic check_all();
        int n;
        n = q.size();
        chk("out_valid", 64'(bus.out_valid), 64'(n > 0));
        chk("occupancy", 64'(bus.occupancy), 64'(n));
        chk("occ_lt3", 64'(bus.occupancy != 2'd3), 64'd1);
        chk("in_ready", 64'(bus.in_ready), 64'(n < 2));
        if (n > 0) begin
            chk("out_wreg", 64'(bus.out_wreg), 64'(q[0].w));
            chk("out_m2reg", 64'(bus.out_m2reg), 64'(q[0].m));
            chk("out_mo", 64'(bus.out_mo), 64'(q[0].mo));
            chk("out_alu", 64'(bus.out_alu), 64'(q[0].alu));
            chk("out_rn", 64'(bus.out_rn), 64'(q[0].rn));
        end else begin
            chk("bubble_wreg", 64'(bus.out_wreg), 64'd0);
            chk("bubble_m2reg", 64'(bus.out_m2reg), 64'd0);
        end
`ifdef PIPE_ELASTIC_PERF_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(bubble_m));
`endif
    endtask
    function automatic beat_t mk(input int rn, input int alu, input bit w);
        beat_t b;
        b.w = w;
        b.m = 1'($urandom);
        b.mo = $urandom;
        b.alu = DW'(alu);
        b.rn = RW'(rn);
        return b;
    endfunction
    function automatic beat_t rnd();
        return mk(int'($urandom_range(31, 0)), int'($urandom), 1'($urandom));
    endfunction
    // One clock: drive inputs, advance the model at the edge, then compare 1 time unit later.
    task automatic step(input bit v, input beat_t b, input bit ordy, input bit fl);
        int n;
        bus.in_valid = v;
        bus.in_wreg = b.w;
        bus.in_m2reg = b.m;
        bus.in_mo = b.mo;
        bus.in_alu = b.alu;
        bus.in_rn = b.rn;
        bus.out_ready = ordy;
        flush = fl;
        @(posedge clock);
        n = q.size();
        if (n > 0 && !ordy && stall_m < CMAX) stall_m++;
        if ((n == 0 || fl) && bubble_m < CMAX) bubble_m++;
        if (fl) q.delete();
        else begin
            if (n > 0 && ordy) void'(q.pop_front());
            if (v && n < 2) q.push_back(b);
        end
        #1 check_all();
    endtask
    task automatic reset_checks();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_wreg", 64'(bus.out_wreg), 64'd0);
        chk("rst_out_m2reg", 64'(bus.out_m2reg), 64'd0);
        chk("rst_out_mo", 64'(bus.out_mo), 64'd0);
        chk("rst_out_alu", 64'(bus.out_alu), 64'd0);
        chk("rst_out_rn", 64'(bus.out_rn), 64'd0);
`ifdef PIPE_ELASTIC_PERF_EN
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
    endtask
    initial begin
        beat_t idle;
        idle = mk(0, 0, 0);
        bus.in_valid = 1'b0;
        bus.in_wreg = 1'b0;
        bus.in_m2reg = 1'b0;
        bus.in_mo = '0;
        bus.in_alu = '0;
        bus.in_rn = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_checks();
        reset = 1'b0;
        // Streaming at full rate.
        for (int r = 1; r <= 8; r++) step(1'b1, mk(r, 32'h100 + r, 1'b1), 1'b1, 1'b0);
        step(1'b0, idle, 1'b1, 1'b0);
        // Backpressure: 3 and 4 fill the stage, 5 waits until space frees.
        step(1'b1, mk(3, 32'h103, 1'b1), 1'b0, 1'b0);
        step(1'b1, mk(4, 32'h104, 1'b1), 1'b0, 1'b0);
        chk("bp_full_occ", 64'(bus.occupancy), 64'd2);
        chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
        step(1'b1, mk(5, 32'h105, 1'b1), 1'b0, 1'b0);
        step(1'b1, mk(5, 32'h105, 1'b1), 1'b1, 1'b0);
        chk("bp_head4", 64'(bus.out_rn), 64'd4);
        step(1'b1, mk(5, 32'h105, 1'b1), 1'b1, 1'b0);
        chk("bp_head5", 64'(bus.out_rn), 64'd5);
        step(1'b0, idle, 1'b1, 1'b0);
        // Flush a full stage while rn 9 is offered.
        step(1'b1, mk(1, 32'h201, 1'b1), 1'b0, 1'b0);
        step(1'b1, mk(2, 32'h202, 1'b1), 1'b0, 1'b0);
        step(1'b1, mk(9, 32'h209, 1'b1), 1'b0, 1'b1);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_wreg", 64'(bus.out_wreg), 64'd0);
        chk("flush_occ", 64'(bus.occupancy), 64'd0);
        // Idle bubbles after drain.
        repeat (3) step(1'b0, idle, 1'b1, 1'b0);
        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++)
            step(1'($urandom), rnd(), 1'($urandom), $urandom_range(15, 0) == 0);
        // Reset asserted mid-cycle with the stage full.
        step(1'b0, idle, 1'b1, 1'b0);
        step(1'b1, rnd(), 1'b0, 1'b0);
        step(1'b1, rnd(), 1'b0, 1'b0);
        chk("pre_rst_occ", 64'(bus.occupancy), 64'd2);
        #2 reset = 1'b1;
        #1 reset_checks();
        q.delete();
        stall_m = 0;
        bubble_m = 0;
        #1 reset = 1'b0;
`ifdef PIPE_ELASTIC_PERF_EN
        step(1'b1, rnd(), 1'b0, 1'b0);
        repeat (5) step(1'b0, idle, 1'b0, 1'b0);
        chk("stall_5", 64'(stall_cnt), 64'd5);
        repeat (20) step(1'b0, idle, 1'b0, 1'b0);
        chk("stall_sat", 64'(stall_cnt), 64'(CMAX));
        repeat (20) step(1'b0, idle, 1'b1, 1'b0);
        chk("bubble_sat", 64'(bubble_cnt), 64'(CMAX));
`else
        repeat (4) step(1'b1, rnd(), 1'b1, 1'b0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
